// File: rtl/prog_loader.sv
// Instruction-memory loader: unpacks a length-prefixed, XOR-checksummed byte stream
// into 16-bit words, writes them into imem in sequence, and holds the CPU until the image verifies.
module prog_loader #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned       TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [31:0]       MAX_WORDS = 32'd1 << ADDR_W;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LEN_HI  = 4'd1;
  localparam logic [3:0] S_LEN_LO  = 4'd2;
  localparam logic [3:0] S_DATA_HI = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
  localparam logic [3:0] S_WRITE   = 4'd5;
  localparam logic [3:0] S_CSUM    = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERR     = 4'd8;

  logic [3:0]        state, state_nxt;
  logic [7:0]        len_msb, len_msb_nxt;
  logic [15:0]       words_left, words_left_nxt;
  logic [7:0]        hi_byte, hi_byte_nxt;
  logic [7:0]        csum, csum_nxt;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [15:0]       mem_wdata_nxt;
  logic              mem_we_nxt;
  logic              accept;
  logic              counting;
  logic [15:0]       len_word;

  // byte_ready is a registered decode of the state, so it is a valid handshake qualifier
  assign accept   = byte_valid && byte_ready;
  assign counting = (state == S_LEN_LO) || (state == S_DATA_HI) ||
                    (state == S_DATA_LO) || (state == S_CSUM);
  assign len_word = {len_msb, byte_data};

  always_comb begin
    state_nxt      = state;
    len_msb_nxt    = len_msb;
    words_left_nxt = words_left;
    hi_byte_nxt    = hi_byte;
    csum_nxt       = csum;
    tmo_cnt_nxt    = tmo_cnt;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    mem_we_nxt     = 1'b0;

    if (counting) tmo_cnt_nxt = accept ? '0 : tmo_cnt + TMO_W'(1);

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nxt    = S_LEN_HI;
          csum_nxt     = '0;
          tmo_cnt_nxt  = '0;
          mem_addr_nxt = BASE;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_msb_nxt = byte_data;
          state_nxt   = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          words_left_nxt = len_word;
          if (len_word == 16'd0)                state_nxt = S_CSUM;
          else if (32'(len_word) > MAX_WORDS)   state_nxt = S_ERR;
          else                                  state_nxt = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_byte_nxt = byte_data;
          csum_nxt    = csum ^ byte_data;
          state_nxt   = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          mem_wdata_nxt = {hi_byte, byte_data};
          csum_nxt      = csum ^ byte_data;
          mem_we_nxt    = 1'b1;
          state_nxt     = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_addr_nxt   = mem_addr + ADDR_W'(1);
        words_left_nxt = words_left - 16'd1;
        state_nxt      = (words_left == 16'd1) ? S_CSUM : S_DATA_HI;
      end
      S_CSUM: begin
        if (accept) state_nxt = (byte_data == csum) ? S_DONE : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase

    // A stalled source inside a load aborts it; LEN_HI may wait indefinitely
    if (counting && !accept && (tmo_cnt == TMO_LAST)) state_nxt = S_ERR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      len_msb    <= '0;
      words_left <= '0;
      hi_byte    <= '0;
      csum       <= '0;
      tmo_cnt    <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nxt;
      len_msb    <= len_msb_nxt;
      words_left <= words_left_nxt;
      hi_byte    <= hi_byte_nxt;
      csum       <= csum_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      byte_ready <= (state_nxt == S_LEN_HI) || (state_nxt == S_LEN_LO) ||
                    (state_nxt == S_DATA_HI) || (state_nxt == S_DATA_LO) ||
                    (state_nxt == S_CSUM);
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      cpu_hold   <= (state_nxt != S_DONE);
      done       <= (state_nxt == S_DONE);
      error      <= (state_nxt == S_ERR);
    end
  end

endmodule
